req_encoder_8to3: RTL and testbench
===================================

REQ_ENCODER_8TO3 -- requirements
Module: req_encoder_8to3

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 The block SHALL have in_valid input 1: request vector offered.
REQ-003 The block SHALL have in_ready output 1: block can accept a vector.
REQ-004 The block SHALL have in_vec input 8: request bits; bit i set means index i pending.
REQ-005 The block SHALL have out_valid output 1: out_idx is valid.
REQ-006 The block SHALL have out_ready input 1: consumer accepts out_idx.
REQ-007 The block SHALL have out_idx output 3: binary index of the set bit currently served.
REQ-008 The block SHALL have out_last output 1: the current index is the final set bit of the vector.
REQ-009 The block SHALL have busy output 1: the block is in state SERVE.

Function
REQ-010 The block SHALL be the inverse of the team's 3-to-8 decoder: it serialises every set bit of an 8-bit vector into 3-bit indices, one per output handshake.
REQ-011 The FSM SHALL have exactly two states, IDLE and SERVE, and SHALL hold an 8-bit pending register.
REQ-012 In IDLE, in_ready SHALL be 1, out_valid 0 and busy 0.
REQ-013 In IDLE, in_valid=1 with in_vec!=0 SHALL load pending<=in_vec and enter SERVE on the same edge.
REQ-014 In IDLE, in_valid=1 with in_vec==0 SHALL be accepted and dropped; the block stays in IDLE with no output.
REQ-015 In SERVE, in_ready SHALL be 0, out_valid 1 and busy 1; in_valid SHALL be ignored.
REQ-016 out_idx SHALL be the scan-order-first set bit of pending, and out_last SHALL be 1 when pending has exactly one bit set.
REQ-017 On an out_valid && out_ready edge, the block SHALL clear the served bit in pending; if out_last=1, it SHALL enter IDLE.
REQ-018 While out_valid=1 and out_ready=0, out_idx, out_last and pending SHALL hold stable.
REQ-019 Latency SHALL be fixed: the first index is valid in the cycle after input acceptance, and each later index is valid in the cycle after the previous handshake.
REQ-020 out_idx and out_last SHALL derive only from registered state, with no combinational path from in_* to out_*.
REQ-021 in_ready SHALL depend only on state, with no combinational path from out_ready.
REQ-022 After a final handshake the block SHALL take one IDLE cycle before it can accept the next vector.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, busy=0 and in_ready=1.
REQ-024 A reset during SERVE SHALL discard all remaining pending indices, and the block SHALL emit no output after reset deassertion until a new vector is accepted.

Configuration
REQ-025 With ENC_MSB_FIRST_EN defined, the scan order SHALL be bit 7 down to bit 0, serving the highest set index first.
REQ-026 Without ENC_MSB_FIRST_EN, the scan order SHALL be bit 0 up to bit 7, serving the lowest set index first.
REQ-027 No other behaviour, port or timing SHALL change with ENC_MSB_FIRST_EN.

Structure
REQ-028 Package enc_pkg SHALL hold VEC_W=8, IDX_W=3 and the state typedef enc_state_t {IDLE, SERVE}.
REQ-029 The block SHALL instantiate one combinational sub-module, prio_enc8, which maps an 8-bit vector to an index, a found flag and a one-bit flag, and carries the scan-order macro.

Verification
REQ-030 Reset check: rst_n low mid-sequence -> out_valid=0, busy=0 and in_ready=1 immediately; no further outputs after release.
REQ-031 Default order: in_vec=8'b1010_0101 with out_ready=1 -> out_idx 0,2,5,7 on consecutive cycles; out_last=1 only on 7; then IDLE.
REQ-032 ENC_MSB_FIRST_EN: in_vec=8'b1010_0101 -> out_idx 7,5,2,0; out_last=1 only on 0.
REQ-033 Backpressure: in_vec=8'h81 with out_ready held 0 for 4 cycles -> out_idx=0 and out_last=0 stable; then idx 0, then idx 7 with out_last=1.
REQ-034 Corner vectors: in_vec=8'h00 -> no out_valid and stays IDLE; in_vec=8'hFF -> 8 indices 0..7 and in_ready=0 throughout.
REQ-035 Input ignored while busy: a second in_valid with 8'h10 during SERVE -> ignored; only indices of the first vector appear.

Source files
------------

// File: rtl/enc_pkg.sv
// ============================================================================
// Module   : enc_pkg
// Brief    : Shared widths and FSM state type for the 8-to-3 request encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package enc_pkg;

  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/prio_enc8.sv
// ============================================================================
// Module   : prio_enc8
// Brief    : Combinational priority encoder; ENC_MSB_FIRST_EN selects the
//            highest set bit, otherwise the lowest set bit wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prio_enc8
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             one
);

  // one is set when exactly a single bit of vec is high
  always_comb begin
    idx   = '0;
    found = |vec;
    one   = found && ((vec & (vec - VEC_W'(1))) == '0);
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < VEC_W; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
`else
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/req_encoder_8to3.sv
// ============================================================================
// Module   : req_encoder_8to3
// Brief    : Serialises each set bit of an 8-bit request vector into 3-bit
//            indices, one per output handshake. Scan order: ENC_MSB_FIRST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module req_encoder_8to3
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  enc_state_t       state_q, state_d;
  logic [VEC_W-1:0] pending_q, pending_d;

  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_one;

  prio_enc8 u_prio_enc8 (
    .vec   (pending_q),
    .idx   (w_idx),
    .found (w_found),
    .one   (w_one)
  );

  // Outputs come straight from registered state and pending_q.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SERVE);
  assign busy      = (state_q == SERVE);
  assign out_idx   = w_idx;
  assign out_last  = (state_q == SERVE) && w_found && w_one;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        // An all-zero vector is accepted but produces nothing.
        if (in_valid && (in_vec != '0)) begin
          pending_d = in_vec;
          state_d   = SERVE;
        end
      end
      SERVE: begin
        if (out_ready) begin
          pending_d = pending_q & ~(VEC_W'(1) << w_idx);
          if (out_last) state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_req_encoder_8to3.sv
// ============================================================================
// Module   : tb_req_encoder_8to3
// Brief    : Scoreboard bench for req_encoder_8to3 (honours ENC_MSB_FIRST_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  req_encoder_8to3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Reference scan order, independent of the DUT's encoder.
  task automatic push_expected(input logic [7:0] v);
    int n = 0;
    int seen = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) begin
`else
    for (int i = 0; i < 8; i++) begin
`endif
      if (v[i]) begin
        exp_t e;
        seen++;
        e.idx  = 3'(i);
        e.last = (seen == n);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge after acceptance.
  task automatic offer(input logic [7:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    push_expected(v);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== (v != 8'h00)) begin
      errors++;
      $display("FAIL latency vec=%h out_valid=%b required=%b", v, out_valid, (v != 8'h00));
    end
  endtask

  // Drain the scoreboard with out_ready=1; out_valid must be high every cycle.
  task automatic drain();
    int budget = 40;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      exp_t e;
      budget--;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL serve_flags out_valid=%b in_ready=%b busy=%b required 1/0/1", out_valid, in_ready, busy);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (out_idx !== e.idx || out_last !== e.last) begin
          errors++;
          $display("FAIL index idx=%0d last=%b required idx=%0d last=%b", out_idx, out_last, e.idx, e.last);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (budget == 0) begin
      errors++;
      $display("FAIL drain_timeout remaining=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state valid=%b busy=%b ready=%b idx=%0d last=%b required 0/0/1/0/0",
               out_valid, busy, in_ready, out_idx, out_last);
    end
  endtask

  task automatic test_default_order();
    offer(8'b1010_0101);
    drain();
  endtask

  task automatic test_backpressure();
    exp_t e;
    offer(8'h81);
    e = exp_q[0];
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== e.idx || out_last !== e.last) begin
        errors++;
        $display("FAIL stall cyc=%0d valid=%b idx=%0d last=%b required 1/%0d/%b",
                 c, out_valid, out_idx, out_last, e.idx, e.last);
      end
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_corner_zero();
    offer(8'h00);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_vec cyc=%0d valid=%b busy=%b ready=%b required 0/0/1", c, out_valid, busy, in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_corner_ff();
    offer(8'hFF);
    drain();
  endtask

  task automatic test_busy_ignore();
    offer(8'h24);
    in_valid = 1'b1;
    in_vec   = 8'h10;
    drain();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    offer(8'h40);
    drain();
    offer(8'h03);
    drain();
  endtask

  task automatic test_reset_mid();
    offer(8'hFF);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid valid=%b busy=%b ready=%b idx=%0d last=%b required 0/0/1/0/0",
               out_valid, busy, in_ready, out_idx, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cyc=%0d out_valid=%b required 0", c, out_valid);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_default_order();
    test_backpressure();
    test_corner_zero();
    test_corner_ff();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_default_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
